snake_step_ctrl: RTL and testbench



---
 rtl/snake_step_ctrl_pkg.sv | 39 +++
 rtl/snake_step_ctrl_dir_queue.sv | 76 +++++++
 rtl/snake_step_ctrl.sv | 140 ++++++++++++++
 tb/tb_snake_step_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_step_ctrl_pkg.sv
// Shared codes for the snake movement scheduler.
// The game-state and direction codes mirror def.v.
package snake_step_ctrl_pkg;

  localparam logic [2:0] MAIN_INIT  = 3'd0;
  localparam logic [2:0] MAIN_WAIT  = 3'd1;
  localparam logic [2:0] MAIN_GAME1 = 3'd2;
  localparam logic [2:0] MAIN_GAME2 = 3'd3;
  localparam logic [2:0] MAIN_GAME3 = 3'd4;
  localparam logic [2:0] MAIN_PAUSE = 3'd5;

  localparam logic [1:0] RIGHT = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] UP    = 2'd2;
  localparam logic [1:0] DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_STEP  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DEAD  = 3'd4
  } step_state_e;

  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    case (d)
      RIGHT:   dir_reverse = LEFT;
      LEFT:    dir_reverse = RIGHT;
      UP:      dir_reverse = DOWN;
      DOWN:    dir_reverse = UP;
      default: dir_reverse = d;
    endcase
  endfunction

  function automatic logic is_game(input logic [2:0] s);
    return (s == MAIN_GAME1) || (s == MAIN_GAME2) || (s == MAIN_GAME3);
  endfunction

endpackage

// File: rtl/snake_step_ctrl_dir_queue.sv
// Two-entry FIFO of pending turns. drop_o flags a request that repeats or
// reverses the reference direction; capacity and game-phase gating are the caller's.
module snake_dir_queue
  import snake_step_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] din_i,
  input  logic [1:0] ref_i,
  output logic [1:0] head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       drop_o
);

  logic [1:0] q0_q, q0_d;
  logic [1:0] q1_q, q1_d;
  logic [1:0] n_q, n_d;
  logic [1:0] ref_s;

  assign empty_o = (n_q == 2'd0);
  assign full_o  = (n_q == 2'd2);
  assign head_o  = q0_q;
  // The tail is the newest pending turn; with nothing pending, the live direction.
  assign ref_s   = full_o ? q1_q : (empty_o ? ref_i : q0_q);
  assign drop_o  = (din_i == ref_s) || (din_i == dir_reverse(ref_s));

  always_comb begin
    q0_d = q0_q;
    q1_d = q1_q;
    n_d  = n_q;
    if (clr_i) begin
      q0_d = RIGHT;
      q1_d = RIGHT;
      n_d  = 2'd0;
    end else begin
      case ({pop_i, push_i})
        2'b10: begin
          q0_d = q1_q;
          n_d  = n_q - 2'd1;
        end
        2'b01: begin
          if (empty_o) q0_d = din_i;
          else         q1_d = din_i;
          n_d = n_q + 2'd1;
        end
        // Pop first: the push lands in whichever slot the pop freed.
        2'b11: begin
          if (full_o) begin
            q0_d = q1_q;
            q1_d = din_i;
          end else begin
            q0_d = din_i;
          end
        end
        default: n_d = n_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q0_q <= RIGHT;
      q1_q <= RIGHT;
      n_q  <= 2'd0;
    end else begin
      q0_q <= q0_d;
      q1_q <= q1_d;
      n_q  <= n_d;
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Movement scheduler: per-level move tick, registered dir_next fed from the
// turn queue, wait for the collision verdict, sticky game-over.
module snake_step_ctrl
  import snake_step_ctrl_pkg::*;
#(
  parameter int PERIOD1 = 25_000_000,
  parameter int PERIOD2 = 15_000_000,
  parameter int PERIOD3 = 8_000_000,
  parameter int CNT_W   = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic       btn_valid,
  input  logic [1:0] btn_dir,
  input  logic       hit_valid,
  input  logic       hit,
  output logic [1:0] dir_next,
  output logic       step,
  output logic       btn_drop,
  output logic       game_over
);

  localparam logic [CNT_W-1:0] TC1 = CNT_W'(PERIOD1 - 1);
  localparam logic [CNT_W-1:0] TC2 = CNT_W'(PERIOD2 - 1);
  localparam logic [CNT_W-1:0] TC3 = CNT_W'(PERIOD3 - 1);

  step_state_e      fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tc_s;
  logic [1:0]       dir_q, dir_d;
  logic             step_q, step_d;
  logic             drop_q, drop_d;
  logic             over_q, over_d;
  logic             clr_s, push_s, pop_s;
  logic [1:0]       q_head_s;
  logic             q_empty_s, q_full_s, q_drop_s;

  snake_dir_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (btn_dir),
    .ref_i   (dir_q),
    .head_o  (q_head_s),
    .empty_o (q_empty_s),
    .full_o  (q_full_s),
    .drop_o  (q_drop_s)
  );

  // Terminal count follows the live level so a speed-up takes effect at once.
  always_comb begin
    case (state)
      MAIN_GAME1: tc_s = TC1;
      MAIN_GAME2: tc_s = TC2;
      MAIN_GAME3: tc_s = TC3;
      default:    tc_s = TC1;
    endcase
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = step_q;
    drop_d = 1'b0;
    over_d = over_q;
    clr_s  = 1'b0;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (state == MAIN_WAIT) begin
      clr_s  = 1'b1;
      fsm_d  = ST_IDLE;
      cnt_d  = {CNT_W{1'b0}};
      dir_d  = RIGHT;
      step_d = 1'b0;
      over_d = 1'b0;
    end else if (is_game(state)) begin
      step_d = 1'b0;
      case (fsm_q)
        ST_IDLE:  fsm_d = ST_COUNT;
        ST_COUNT: begin
          if (cnt_q >= tc_s) begin
            cnt_d  = {CNT_W{1'b0}};
            fsm_d  = ST_STEP;
            step_d = 1'b1;
            pop_s  = !q_empty_s;
            if (!q_empty_s) dir_d = q_head_s;
            else            dir_d = dir_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STEP:  fsm_d = ST_CHECK;
        ST_CHECK: begin
          if (hit_valid && hit) begin
            fsm_d  = ST_DEAD;
            over_d = 1'b1;
          end else if (hit_valid) begin
            fsm_d = ST_COUNT;
          end else begin
            fsm_d = ST_CHECK;
          end
        end
        ST_DEAD:  fsm_d = ST_DEAD;
        default:  fsm_d = ST_IDLE;
      endcase
      // A full queue still takes the push when the head leaves this cycle.
      push_s = btn_valid && (fsm_q != ST_DEAD) && !q_drop_s && !(q_full_s && !pop_s);
      drop_d = btn_valid && !push_s;
    end else begin
      fsm_d = fsm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= ST_IDLE;
      cnt_q  <= {CNT_W{1'b0}};
      dir_q  <= RIGHT;
      step_q <= 1'b0;
      drop_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      drop_q <= drop_d;
      over_q <= over_d;
    end
  end

  assign dir_next  = dir_q;
  assign step      = step_q;
  assign btn_drop  = drop_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Self-checking bench for snake_step_ctrl with shortened periods (5/3/2)
// and a transaction-level reference model of the scheduler and turn queue.
module tb_snake_step_ctrl;
  import snake_step_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state = MAIN_WAIT;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_dir = RIGHT;
  logic       hit_valid = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] dir_next;
  logic       step, btn_drop, game_over;

  int tests_run = 0;
  int tests_failed = 0;

  snake_step_ctrl #(.PERIOD1(5), .PERIOD2(3), .PERIOD3(2), .CNT_W(25)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .btn_valid(btn_valid), .btn_dir(btn_dir),
    .hit_valid(hit_valid), .hit(hit), .dir_next(dir_next), .step(step),
    .btn_drop(btn_drop), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the move cycle, ticks counted, pending turns.
  typedef enum int {P_IDLE, P_COUNT, P_STEP, P_CHECK, P_DEAD} phase_t;
  phase_t     m_phase;
  int         m_cnt;
  logic [1:0] m_dir;
  logic [1:0] mq[$];
  logic       e_step, e_drop, e_go;

  function automatic int period_of(input logic [2:0] st);
    if (st == MAIN_GAME1) return 5;
    if (st == MAIN_GAME2) return 3;
    return 2;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    logic [1:0] tbl [4];
    tbl[RIGHT] = LEFT; tbl[LEFT] = RIGHT; tbl[UP] = DOWN; tbl[DOWN] = UP;
    return tbl[d];
  endfunction

  function automatic bit playing(input logic [2:0] st);
    return st == MAIN_GAME1 || st == MAIN_GAME2 || st == MAIN_GAME3;
  endfunction

  task automatic drive(input logic rn, input logic [2:0] st, input logic bv,
                       input logic [1:0] bd, input logic hv, input logic h);
    logic [1:0] refd;
    bit fire, take;
    rst_n = rn; state = st; btn_valid = bv; btn_dir = bd; hit_valid = hv; hit = h;
    if (!rn || st == MAIN_WAIT) begin
      m_phase = P_IDLE; m_cnt = 0; m_dir = RIGHT; mq.delete();
      e_step = 1'b0; e_drop = 1'b0; e_go = 1'b0;
    end else if (!playing(st)) begin
      e_drop = 1'b0;
    end else begin
      refd = (mq.size() > 0) ? mq[$] : m_dir;
      fire = (m_phase == P_COUNT) && (m_cnt >= period_of(st) - 1);
      take = 0;
      e_drop = 1'b0;
      e_step = 1'b0;
      if (bv) begin
        if (m_phase == P_DEAD || bd == refd || bd == opposite(refd) ||
            (mq.size() == 2 && !fire)) e_drop = 1'b1;
        else take = 1;
      end
      case (m_phase)
        P_IDLE:  m_phase = P_COUNT;
        P_COUNT: begin
          if (fire) begin
            m_cnt = 0;
            if (mq.size() > 0) m_dir = mq.pop_front();
            m_phase = P_STEP;
            e_step = 1'b1;
          end else m_cnt++;
        end
        P_STEP:  m_phase = P_CHECK;
        P_CHECK: if (hv) begin
          if (h) begin m_phase = P_DEAD; e_go = 1'b1; end
          else m_phase = P_COUNT;
        end
        default: ;
      endcase
      if (take) mq.push_back(bd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int first = -1;
    drive(1'b0, MAIN_GAME1, 1'b0, RIGHT, 1'b0, 1'b0);
    drive(1'b0, MAIN_GAME1, 1'b1, UP, 1'b0, 1'b0);
    tests_run++; if (dir_next !== RIGHT) begin tests_failed++; $display("FAIL reset_dir: got %0d required %0d", dir_next, RIGHT); end
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL reset_step: got %b required 0", step); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL reset_over: got %b required 0", game_over); end
    tests_run++; if (btn_drop !== 1'b0) begin tests_failed++; $display("FAIL reset_drop: got %b required 0", btn_drop); end
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, MAIN_GAME1, 1'b0, RIGHT, 1'b0, 1'b0);
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {m_dir, e_step, e_drop, e_go}) begin
        tests_failed++;
        $display("FAIL reset_cycle %0d: got %b required %b", k, {dir_next, step, btn_drop, game_over}, {m_dir, e_step, e_drop, e_go});
      end
      if (step === 1'b1 && first < 0) first = k;
    end
    tests_run++; if (first != 6) begin tests_failed++; $display("FAIL reset_first_step: got cycle %0d required 6", first); end
  endtask

  task automatic test_reversal;
    logic [1:0] prev = RIGHT;
    bit got = 0;
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    drive(1'b1, MAIN_GAME1, 1'b1, LEFT, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b1) begin tests_failed++; $display("FAIL rev_left_drop: got %b required 1", btn_drop); end
    drive(1'b1, MAIN_GAME1, 1'b1, RIGHT, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b1) begin tests_failed++; $display("FAIL dup_right_drop: got %b required 1", btn_drop); end
    drive(1'b1, MAIN_GAME1, 1'b1, UP, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b0) begin tests_failed++; $display("FAIL accept_up: got %b required 0", btn_drop); end
    for (int k = 0; k < 10 && !got; k++) begin
      prev = dir_next;
      drive(1'b1, MAIN_GAME1, 1'b0, RIGHT, 1'b0, 1'b0);
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {m_dir, e_step, e_drop, e_go}) begin
        tests_failed++;
        $display("FAIL rev_cycle %0d: got %b required %b", k, {dir_next, step, btn_drop, game_over}, {m_dir, e_step, e_drop, e_go});
      end
      if (step === 1'b1) got = 1;
    end
    tests_run++;
    if (!got || dir_next !== UP || prev !== RIGHT) begin
      tests_failed++;
      $display("FAIL rev_step_dir: got step_seen=%0d dir=%0d before=%0d required 1/%0d/%0d", got, dir_next, prev, UP, RIGHT);
    end
  endtask

  task automatic test_queue_full;
    logic [1:0] seen [2];
    int n = 0;
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    drive(1'b1, MAIN_GAME1, 1'b1, UP, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b0) begin tests_failed++; $display("FAIL full_up: got %b required 0", btn_drop); end
    drive(1'b1, MAIN_GAME1, 1'b1, LEFT, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b0) begin tests_failed++; $display("FAIL full_left: got %b required 0", btn_drop); end
    drive(1'b1, MAIN_GAME1, 1'b1, DOWN, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b1) begin tests_failed++; $display("FAIL full_down_drop: got %b required 1", btn_drop); end
    for (int k = 0; k < 30 && n < 2; k++) begin
      drive(1'b1, MAIN_GAME1, 1'b0, RIGHT, 1'b1, 1'b0);
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {m_dir, e_step, e_drop, e_go}) begin
        tests_failed++;
        $display("FAIL full_cycle %0d: got %b required %b", k, {dir_next, step, btn_drop, game_over}, {m_dir, e_step, e_drop, e_go});
      end
      if (step === 1'b1) begin seen[n] = dir_next; n++; end
    end
    tests_run++;
    if (n != 2 || seen[0] !== UP || seen[1] !== LEFT) begin
      tests_failed++;
      $display("FAIL full_order: got %0d steps first=%0d second=%0d required 2/%0d/%0d", n, seen[0], seen[1], UP, LEFT);
    end
  endtask

  task automatic test_level_change;
    int first = -1, steps = 0;
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, MAIN_GAME1, 1'b0, RIGHT, 1'b0, 1'b0);
    drive(1'b1, MAIN_GAME3, 1'b0, RIGHT, 1'b0, 1'b0);
    tests_run++; if (step !== 1'b1) begin tests_failed++; $display("FAIL lvl_immediate: got %b required 1", step); end
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, MAIN_GAME3, 1'b0, RIGHT, 1'b1, 1'b0);
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {m_dir, e_step, e_drop, e_go}) begin
        tests_failed++;
        $display("FAIL lvl_cycle %0d: got %b required %b", k, {dir_next, step, btn_drop, game_over}, {m_dir, e_step, e_drop, e_go});
      end
      if (step === 1'b1) begin steps++; if (first < 0) first = k; end
    end
    tests_run++;
    if (steps != 3 || first != 4) begin
      tests_failed++;
      $display("FAIL lvl_cadence: got %0d steps first at %0d required 3 steps first at 4", steps, first);
    end
  endtask

  task automatic test_collision;
    bit got = 0;
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !got; k++) begin
      drive(1'b1, MAIN_GAME3, 1'b0, RIGHT, 1'b0, 1'b0);
      if (step === 1'b1) got = 1;
    end
    tests_run++; if (!got) begin tests_failed++; $display("FAIL col_step_timeout: got no step required one"); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, MAIN_GAME3, 1'b0, RIGHT, 1'b0, 1'b0);
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {m_dir, e_step, e_drop, e_go} || step !== 1'b0) begin
        tests_failed++;
        $display("FAIL col_wait %0d: got %b required %b", k, {dir_next, step, btn_drop, game_over}, {m_dir, e_step, e_drop, e_go});
      end
    end
    drive(1'b1, MAIN_GAME3, 1'b0, RIGHT, 1'b1, 1'b1);
    tests_run++; if (game_over !== 1'b1) begin tests_failed++; $display("FAIL col_over: got %b required 1", game_over); end
    drive(1'b1, MAIN_GAME3, 1'b1, UP, 1'b0, 1'b0);
    tests_run++; if (btn_drop !== 1'b1) begin tests_failed++; $display("FAIL col_dead_drop: got %b required 1", btn_drop); end
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, MAIN_GAME3, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tests_run++;
      if (game_over !== 1'b1 || step !== 1'b0) begin
        tests_failed++;
        $display("FAIL col_sticky %0d: got over=%b step=%b required 1/0", k, game_over, step);
      end
    end
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    tests_run++;
    if (game_over !== 1'b0 || dir_next !== RIGHT) begin
      tests_failed++;
      $display("FAIL col_wait_clear: got over=%b dir=%0d required 0/%0d", game_over, dir_next, RIGHT);
    end
  endtask

  task automatic test_freeze;
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    drive(1'b1, MAIN_GAME1, 1'b0, RIGHT, 1'b0, 1'b0);
    drive(1'b1, MAIN_GAME1, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, MAIN_PAUSE, 1'b1, UP, 1'b1, 1'b1);
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {RIGHT, 1'b0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL freeze_hold %0d: got %b required %b", k, {dir_next, step, btn_drop, game_over}, {RIGHT, 3'b000});
      end
    end
    drive(1'b1, MAIN_GAME2, 1'b0, RIGHT, 1'b0, 1'b0);
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL freeze_resume_early: got %b required 0", step); end
    drive(1'b1, MAIN_GAME2, 1'b0, RIGHT, 1'b0, 1'b0);
    tests_run++;
    if (step !== 1'b1 || dir_next !== RIGHT) begin
      tests_failed++;
      $display("FAIL freeze_resume_step: got step=%b dir=%0d required 1/%0d", step, dir_next, RIGHT);
    end
  endtask

  task automatic test_random;
    logic [2:0] st;
    int r;
    drive(1'b1, MAIN_WAIT, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 39);
      st = (r == 0) ? MAIN_WAIT : (r < 3) ? MAIN_PAUSE : (r < 18) ? MAIN_GAME1 :
           (r < 30) ? MAIN_GAME2 : MAIN_GAME3;
      drive(1'($urandom_range(0, 199) != 0), st, 1'($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0));
      tests_run++;
      if ({dir_next, step, btn_drop, game_over} !== {m_dir, e_step, e_drop, e_go}) begin
        tests_failed++;
        $display("FAIL rand_cycle %0d: got %b required %b", i, {dir_next, step, btn_drop, game_over}, {m_dir, e_step, e_drop, e_go});
      end
    end
  endtask

  initial begin
    test_reset();
    test_reversal();
    test_queue_full();
    test_level_change();
    test_collision();
    test_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
